ysyx_25040129_wbu: RTL and testbench

Write-back / commit stage, directly downstream of the LSU. It accepts one retiring instruction per valid/ready handshake and performs these actions:
- writes the GPR file;
- owns the machine CSR file;
- applies ecall/mret trap side effects;
- sequences fence.i I-cache flushes;
- issues registered control-flow redirects to the IFU.

It is the single architectural commit point of the core.

---
 rtl/ysyx_25040129_wbu_pkg.sv | 36 +++
 rtl/ysyx_25040129_csr_file.sv | 87 ++++++++
 rtl/ysyx_25040129_wbu.sv | 129 ++++++++++++
 tb/tb_ysyx_25040129_wbu.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_wbu_pkg.sv
// Shared constants for the write-back stage: CSR map, trap codes, mstatus fields
// and the commit FSM state type.
package ysyx_25040129_wbu_pkg;

    localparam int REGS_DIG = 4;
    localparam int CSR_DIG  = 3;

    localparam logic [CSR_DIG-1:0] CSR_MSTATUS   = 3'd0;
    localparam logic [CSR_DIG-1:0] CSR_MTVEC     = 3'd1;
    localparam logic [CSR_DIG-1:0] CSR_MEPC      = 3'd2;
    localparam logic [CSR_DIG-1:0] CSR_MCAUSE    = 3'd3;
    localparam logic [CSR_DIG-1:0] CSR_MVENDORID = 3'd4;
    localparam logic [CSR_DIG-1:0] CSR_MARCHID   = 3'd5;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL    = 32'd25040129;
    localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } wbu_state_e;

    // Only the four trap-related CSRs accept software writes.
    function automatic logic csr_writable(input logic [CSR_DIG-1:0] idx);
        return (idx <= CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_25040129_csr_file.sv
// Machine CSR storage with software write port, ecall/mret update port and a
// combinational read mux.
module ysyx_25040129_csr_file
    import ysyx_25040129_wbu_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  logic [CSR_DIG-1:0] csr_waddr,
    input  logic [31:0]        csr_wdata,
    input  logic               trap_ecall,
    input  logic               trap_mret,
    input  logic [31:0]        trap_pc,
    input  logic [CSR_DIG-1:0] csr_raddr,
    output logic [31:0]        csr_rdata,
    output logic [31:0]        mtvec,
    output logic [31:0]        mepc
);

    logic [31:0] mstatus_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;

    function automatic logic [31:0] mstatus_on_ecall(input logic [31:0] m);
        logic [31:0] r;
        r               = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r               = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Software writes first; trap updates are later NBAs so they win on the same CSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= MTVEC_RST;
            mepc_r    <= 32'h0000_0000;
            mcause_r  <= 32'h0000_0000;
        end else begin
            if (csr_we && csr_writable(csr_waddr)) begin
                case (csr_waddr)
                    CSR_MSTATUS: mstatus_r <= csr_wdata;
                    CSR_MTVEC:   mtvec_r   <= csr_wdata;
                    CSR_MEPC:    mepc_r    <= csr_wdata;
                    CSR_MCAUSE:  mcause_r  <= csr_wdata;
                    default:     ;
                endcase
            end
            if (trap_ecall) begin
                mepc_r    <= trap_pc;
                mcause_r  <= MCAUSE_ECALL_M;
                mstatus_r <= mstatus_on_ecall(mstatus_r);
            end else if (trap_mret) begin
                mstatus_r <= mstatus_on_mret(mstatus_r);
            end
        end
    end

    // Read mux: current register contents, no write bypass.
    always_comb begin
        csr_rdata = 32'h0000_0000;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus_r;
            CSR_MTVEC:     csr_rdata = mtvec_r;
            CSR_MEPC:      csr_rdata = mepc_r;
            CSR_MCAUSE:    csr_rdata = mcause_r;
            CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
            CSR_MARCHID:   csr_rdata = MARCHID_VAL;
            default:       csr_rdata = 32'h0000_0000;
        endcase
    end

    assign mtvec = mtvec_r;
    assign mepc  = mepc_r;

endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Write-back / commit stage: GPR write port, CSR file, trap side effects,
// fence.i flush sequencing and registered IFU redirects.
module ysyx_25040129_wbu
    import ysyx_25040129_wbu_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_req_valid_from_lsu,
    output logic                is_req_ready_to_lsu,
    input  logic [31:0]         pc_in_wbu,
    input  logic [31:0]         result_in_wbu,
    input  logic [31:0]         branch_target_in_wbu,
    input  logic                reg_write_in_wbu,
    input  logic [REGS_DIG-1:0] rd_in_wbu,
    input  logic                csr_write_in_wbu,
    input  logic [CSR_DIG-1:0]  csr_addr_in_wbu,
    input  logic                ecall_in_wbu,
    input  logic                mret_in_wbu,
    input  logic                is_branch_in_wbu,
    input  logic                fence_i_in_wbu,
    output logic                rf_wen,
    output logic [REGS_DIG-1:0] rf_waddr,
    output logic [31:0]         rf_wdata,
    input  logic [CSR_DIG-1:0]  csr_raddr,
    output logic [31:0]         csr_rdata,
    output logic                fence_i_req,
    input  logic                fence_i_done,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    input  logic                redirect_ready,
    output logic                retire
);

    wbu_state_e  state_r;
    logic        redirect_valid_r;
    logic        fence_i_req_r;
    logic [31:0] redirect_pc_r;
    logic        fire_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] mtvec_s;
    logic [31:0] mepc_s;

    assign is_req_ready_to_lsu = (state_r == ST_IDLE);
    assign fire_s              = is_req_valid_from_lsu && is_req_ready_to_lsu;
    assign pc_plus4_s          = pc_in_wbu + 32'd4;

    assign rf_wen   = fire_s && reg_write_in_wbu && (rd_in_wbu != {REGS_DIG{1'b0}});
    assign rf_waddr = rd_in_wbu;
    assign rf_wdata = result_in_wbu;
    assign retire   = fire_s;

    ysyx_25040129_csr_file #(
        .MTVEC_RST (MTVEC_RST)
    ) u_csr_file (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (fire_s && csr_write_in_wbu),
        .csr_waddr  (csr_addr_in_wbu),
        .csr_wdata  (result_in_wbu),
        .trap_ecall (fire_s && ecall_in_wbu),
        .trap_mret  (fire_s && mret_in_wbu && !ecall_in_wbu),
        .trap_pc    (pc_in_wbu),
        .csr_raddr  (csr_raddr),
        .csr_rdata  (csr_rdata),
        .mtvec      (mtvec_s),
        .mepc       (mepc_s)
    );

    // Commit FSM: picks the redirect source by priority ecall > mret > fence.i > branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            fence_i_req_r    <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_s) begin
                        if (ecall_in_wbu) begin
                            redirect_pc_r    <= mtvec_s;
                            redirect_valid_r <= 1'b1;
                            state_r          <= ST_REDIRECT;
                        end else if (mret_in_wbu) begin
                            redirect_pc_r    <= mepc_s;
                            redirect_valid_r <= 1'b1;
                            state_r          <= ST_REDIRECT;
                        end else if (fence_i_in_wbu) begin
                            redirect_pc_r    <= pc_plus4_s;
                            fence_i_req_r    <= 1'b1;
                            state_r          <= ST_FLUSH;
                        end else if (is_branch_in_wbu) begin
                            redirect_pc_r    <= branch_target_in_wbu;
                            redirect_valid_r <= 1'b1;
                            state_r          <= ST_REDIRECT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fence_i_done) begin
                        fence_i_req_r    <= 1'b0;
                        redirect_valid_r <= 1'b1;
                        state_r          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_r <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                end
                default: begin
                    redirect_valid_r <= 1'b0;
                    fence_i_req_r    <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign fence_i_req    = fence_i_req_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Self-checking bench for the write-back stage: GPR vector table, directed trap /
// flush / reset sequences and randomized commits against a CSR/redirect model.
module tb_ysyx_25040129_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_req_valid_from_lsu;
    logic        is_req_ready_to_lsu;
    logic [31:0] pc_in_wbu, result_in_wbu, branch_target_in_wbu;
    logic        reg_write_in_wbu;
    logic [3:0]  rd_in_wbu;
    logic        csr_write_in_wbu;
    logic [2:0]  csr_addr_in_wbu;
    logic        ecall_in_wbu, mret_in_wbu, is_branch_in_wbu, fence_i_in_wbu;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  csr_raddr;
    logic [31:0] csr_rdata;
    logic        fence_i_req, fence_i_done;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        retire;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_csr [0:3];

    typedef struct {
        logic [31:0] pc, result, target;
        logic        rw;
        logic [3:0]  rd;
        logic        cw;
        logic [2:0]  ca;
        logic        ecall, mret, fence, br;
    } instr_t;

    typedef struct {
        logic [3:0]  rd;
        logic        rw;
        logic [31:0] result;
        logic        exp_wen;
    } gpr_vec_t;

    ysyx_25040129_wbu dut (
        .clk(clk), .rst(rst),
        .is_req_valid_from_lsu(is_req_valid_from_lsu), .is_req_ready_to_lsu(is_req_ready_to_lsu),
        .pc_in_wbu(pc_in_wbu), .result_in_wbu(result_in_wbu), .branch_target_in_wbu(branch_target_in_wbu),
        .reg_write_in_wbu(reg_write_in_wbu), .rd_in_wbu(rd_in_wbu),
        .csr_write_in_wbu(csr_write_in_wbu), .csr_addr_in_wbu(csr_addr_in_wbu),
        .ecall_in_wbu(ecall_in_wbu), .mret_in_wbu(mret_in_wbu),
        .is_branch_in_wbu(is_branch_in_wbu), .fence_i_in_wbu(fence_i_in_wbu),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .fence_i_req(fence_i_req), .fence_i_done(fence_i_done),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .retire(retire)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_csr(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return m_csr[idx[1:0]];
            3'd4:    return 32'h7973_7978;
            3'd5:    return 32'd25040129;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_csr[0] = 32'h0000_1800;
        m_csr[1] = 32'h0000_0000;
        m_csr[2] = 32'h0000_0000;
        m_csr[3] = 32'h0000_0000;
    endtask

    task automatic clear_inputs();
        is_req_valid_from_lsu = 1'b0;
        pc_in_wbu = 32'd0; result_in_wbu = 32'd0; branch_target_in_wbu = 32'd0;
        reg_write_in_wbu = 1'b0; rd_in_wbu = 4'd0;
        csr_write_in_wbu = 1'b0; csr_addr_in_wbu = 3'd0;
        ecall_in_wbu = 1'b0; mret_in_wbu = 1'b0;
        is_branch_in_wbu = 1'b0; fence_i_in_wbu = 1'b0;
    endtask

    task automatic check_csrs();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            csr_raddr = idx;
            #1;
            check($sformatf("csr%0d", i), csr_rdata, exp_csr(idx));
        end
    endtask

    task automatic handle_ctrl(input logic is_fence, input logic [31:0] exp_pc,
                               input int fhold, input int rhold);
        if (is_fence) begin
            check("fence_req_set", 32'(fence_i_req), 32'd1);
            check("flush_no_rv", 32'(redirect_valid), 32'd0);
            for (int k = 0; k < fhold; k++) begin
                tick();
                check("fence_req_hold", 32'(fence_i_req), 32'd1);
                check("flush_ready", 32'(is_req_ready_to_lsu), 32'd0);
            end
            fence_i_done = 1'b1;
            tick();
            fence_i_done = 1'b0;
            check("fence_req_drop", 32'(fence_i_req), 32'd0);
        end
        check("redirect_valid", 32'(redirect_valid), 32'd1);
        check("redirect_pc", redirect_pc, exp_pc);
        check("busy_ready", 32'(is_req_ready_to_lsu), 32'd0);
        for (int k = 0; k < rhold; k++) begin
            logic [31:0] r;
            r = $urandom();
            fence_i_done = r[0];
            tick();
            fence_i_done = 1'b0;
            check("rv_hold", 32'(redirect_valid), 32'd1);
            check("rpc_stable", redirect_pc, exp_pc);
            check("rd_no_fence", 32'(fence_i_req), 32'd0);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("rv_clear", 32'(redirect_valid), 32'd0);
        check("ready_back", 32'(is_req_ready_to_lsu), 32'd1);
    endtask

    task automatic fire_instr(input instr_t t, input int fhold, input int rhold);
        logic [31:0] exp_pc, old_ms, ms;
        int kind;
        pc_in_wbu = t.pc; result_in_wbu = t.result; branch_target_in_wbu = t.target;
        reg_write_in_wbu = t.rw; rd_in_wbu = t.rd;
        csr_write_in_wbu = t.cw; csr_addr_in_wbu = t.ca;
        ecall_in_wbu = t.ecall; mret_in_wbu = t.mret;
        fence_i_in_wbu = t.fence; is_branch_in_wbu = t.br;
        csr_raddr = t.ca;
        is_req_valid_from_lsu = 1'b1;
        #1;
        check("accept_ready", 32'(is_req_ready_to_lsu), 32'd1);
        check("retire", 32'(retire), 32'd1);
        check("rf_wen", 32'(rf_wen), 32'(t.rw && (t.rd != 4'd0)));
        check("csr_no_bypass", csr_rdata, exp_csr(t.ca));
        if (t.rw && (t.rd != 4'd0)) begin
            check("rf_waddr", 32'(rf_waddr), 32'(t.rd));
            check("rf_wdata", rf_wdata, t.result);
        end
        old_ms = m_csr[0];
        kind = 0;
        exp_pc = 32'd0;
        if (t.ecall)      begin kind = 1; exp_pc = m_csr[1]; end
        else if (t.mret)  begin kind = 2; exp_pc = m_csr[2]; end
        else if (t.fence) begin kind = 3; exp_pc = t.pc + 32'd4; end
        else if (t.br)    begin kind = 4; exp_pc = t.target; end
        if (t.cw && (t.ca < 3'd4)) m_csr[t.ca[1:0]] = t.result;
        if (t.ecall) begin
            m_csr[2] = t.pc;
            m_csr[3] = 32'd11;
            ms = old_ms; ms[7] = old_ms[3]; ms[3] = 1'b0;
            m_csr[0] = ms;
        end else if (t.mret) begin
            ms = old_ms; ms[3] = old_ms[7]; ms[7] = 1'b1;
            m_csr[0] = ms;
        end
        tick();
        clear_inputs();
        if (kind != 0) handle_ctrl(kind == 3, exp_pc, fhold, rhold);
    endtask

    function automatic instr_t plain();
        instr_t t;
        t.pc = 32'd0; t.result = 32'd0; t.target = 32'd0;
        t.rw = 1'b0; t.rd = 4'd0; t.cw = 1'b0; t.ca = 3'd0;
        t.ecall = 1'b0; t.mret = 1'b0; t.fence = 1'b0; t.br = 1'b0;
        return t;
    endfunction

    initial begin
        gpr_vec_t vecs [6];
        instr_t   t;
        vecs[0] = '{4'd5,  1'b1, 32'h0000_1234, 1'b1};
        vecs[1] = '{4'd0,  1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{4'd15, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{4'd3,  1'b0, 32'h0000_0055, 1'b0};
        vecs[4] = '{4'd1,  1'b1, 32'h0000_0000, 1'b1};
        vecs[5] = '{4'd9,  1'b1, 32'hA5A5_5A5A, 1'b1};

        clear_inputs();
        csr_raddr = 3'd0; fence_i_done = 1'b0; redirect_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(is_req_ready_to_lsu), 32'd1);
        check("rst_rv", 32'(redirect_valid), 32'd0);
        check("rst_fence", 32'(fence_i_req), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check_csrs();

        // GPR write table, back-to-back
        for (int i = 0; i < 6; i++) begin
            rd_in_wbu = vecs[i].rd; reg_write_in_wbu = vecs[i].rw;
            result_in_wbu = vecs[i].result; is_req_valid_from_lsu = 1'b1;
            #1;
            check($sformatf("vec%0d_wen", i), 32'(rf_wen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].rd));
            check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].result);
            check($sformatf("vec%0d_retire", i), 32'(retire), 32'd1);
            tick();
        end
        clear_inputs();

        // CSR write visibility and read-only index
        t = plain(); t.cw = 1'b1; t.ca = 3'd1; t.result = 32'h8000_0100;
        fire_instr(t, 0, 0);
        csr_raddr = 3'd1; #1;
        check("mtvec_written", csr_rdata, 32'h8000_0100);
        t = plain(); t.cw = 1'b1; t.ca = 3'd4; t.result = 32'h1111_2222;
        fire_instr(t, 0, 0);
        csr_raddr = 3'd4; #1;
        check("mvendorid_ro", csr_rdata, 32'h7973_7978);

        // ecall with redirect held off for three cycles
        t = plain(); t.cw = 1'b1; t.ca = 3'd0; t.result = 32'h0000_1808;
        fire_instr(t, 0, 0);
        t = plain(); t.ecall = 1'b1; t.pc = 32'h8000_0040;
        fire_instr(t, 0, 3);
        csr_raddr = 3'd0; #1; check("ecall_mstatus", csr_rdata, 32'h0000_1880);
        csr_raddr = 3'd2; #1; check("ecall_mepc", csr_rdata, 32'h8000_0040);
        csr_raddr = 3'd3; #1; check("ecall_mcause", csr_rdata, 32'd11);

        // mret back to the trapping pc
        t = plain(); t.mret = 1'b1;
        fire_instr(t, 0, 1);
        csr_raddr = 3'd0; #1; check("mret_mstatus", csr_rdata, 32'h0000_1888);

        // fence.i at the top of the address space wraps to 0
        t = plain(); t.fence = 1'b1; t.pc = 32'hFFFF_FFFC;
        fire_instr(t, 4, 0);

        // stray done pulse in IDLE is ignored
        fence_i_done = 1'b1; tick(); fence_i_done = 1'b0;
        check("stray_done_fence", 32'(fence_i_req), 32'd0);
        check("stray_done_ready", 32'(is_req_ready_to_lsu), 32'd1);

        // branch with next instruction already valid, then reset during REDIRECT
        pc_in_wbu = 32'h8000_0100; branch_target_in_wbu = 32'h8000_0200;
        is_branch_in_wbu = 1'b1; is_req_valid_from_lsu = 1'b1;
        #1;
        check("br_retire", 32'(retire), 32'd1);
        tick();
        is_branch_in_wbu = 1'b0; reg_write_in_wbu = 1'b1; rd_in_wbu = 4'd7;
        #1;
        check("br_ready_drop", 32'(is_req_ready_to_lsu), 32'd0);
        check("br_no_retire", 32'(retire), 32'd0);
        check("br_no_wen", 32'(rf_wen), 32'd0);
        check("br_rv", 32'(redirect_valid), 32'd1);
        check("br_rpc", redirect_pc, 32'h8000_0200);
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        model_reset();
        check("rst_mid_rv", 32'(redirect_valid), 32'd0);
        check("rst_mid_ready", 32'(is_req_ready_to_lsu), 32'd1);
        csr_raddr = 3'd0; #1; check("rst_mid_mstatus", csr_rdata, 32'h0000_1800);
        check_csrs();

        // randomized commits against the model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] r;
            int sel;
            r = $urandom();
            sel = int'($urandom_range(0, 9));
            t = plain();
            t.pc = $urandom(); t.result = $urandom(); t.target = $urandom();
            t.rw = r[0]; t.rd = r[4:1]; t.cw = r[5]; t.ca = r[8:6];
            t.ecall = (sel == 0) || (r[15:12] == 4'd0);
            t.mret  = (sel == 1) || (r[19:16] == 4'd0);
            t.fence = (sel == 2) || (r[23:20] == 4'd0);
            t.br    = (sel == 3) || (r[27:24] == 4'd0);
            fire_instr(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ((n % 25) == 24) check_csrs();
        end
        check_csrs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
